// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage buffer: plain register (DEPTH=1) or skid pair (DEPTH=2).
// Flush and stall come from the hazard unit; outputs are driven straight from flops.
module pipe_stage_buf #(
    parameter int DATA_W       = 256,
    parameter int DEPTH        = 2,
    parameter int CLR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        occupancy_o
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_head_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_valid;
    logic              w_ready;
    logic              w_in_fire;
    logic              w_out_fire;

    // The skid variant must not see out_ready_i, so its ready is pure state.
    generate
        if (DEPTH == 1) begin : g_plain
            assign w_ready = !stall_i
                & ((r_state == S_EMPTY) | out_ready_i);
        end else begin : g_skid
            assign w_ready = !stall_i & (r_state != S_TWO);
        end
    endgenerate

    assign in_ready_o  = w_ready & !rst;
    assign w_in_fire   = in_valid_i & in_ready_o;
    assign w_out_fire  = r_valid & out_ready_i & !stall_i;

    assign out_valid_o = r_valid;
    assign out_data_o  = r_head;
    assign occupancy_o = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = S_ONE;
                    w_head_nxt  = in_data_i;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_head_nxt = in_data_i;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_in_fire && DEPTH == 2) begin
                    w_state_nxt = S_TWO;
                    w_skid_nxt  = in_data_i;
                end
            end
            S_TWO: begin
                if (w_out_fire) begin
                    w_state_nxt = S_ONE;
                    w_head_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_skid  <= '0;
        end else if (flush_i) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
            r_skid  <= '0;
            if (CLR_ON_FLUSH != 0) begin
                r_head <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != S_EMPTY);
            r_head  <= w_head_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 256, width of the payload bus carried through the stage.
REQ-002 Parameter DEPTH, default 2, number of entries; legal values 1 (plain stage) and 2 (skid stage).
REQ-003 Parameter CLR_ON_FLUSH, default 1, when 1 out_data_o is zeroed by flush; when 0 out_data_o keeps its last value.
REQ-004 clk  input  1  stage clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush_i  input  1  discard all held entries (exception/branch kill).
REQ-007 stall_i  input  1  hazard-unit freeze; no accept, no release.
REQ-008 in_valid_i  input  1  upstream presents payload.
REQ-009 in_data_i  input  DATA_W  upstream payload.
REQ-010 in_ready_o  output  1  stage can accept this cycle.
REQ-011 out_valid_o  output  1  head entry valid toward downstream.
REQ-012 out_data_o  output  DATA_W  head entry payload.
REQ-013 out_ready_i  input  1  downstream accepts head.
REQ-014 occupancy_o  output  2  entries held, 0..DEPTH.

Function
REQ-015 in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i & !stall_i.
REQ-016 States: EMPTY (0 entries), ONE (1), TWO (2, DEPTH=2 only); occupancy_o equals state count.
REQ-017 DEPTH=1: in_ready_o = !stall_i & (EMPTY | out_ready_i) (combinational pass-through of downstream ready).
REQ-018 DEPTH=2: in_ready_o = !stall_i & (state != TWO), from registered state only; no combinational path from out_ready_i to in_ready_o.
REQ-019 Transitions: EMPTY->ONE on in_fire; ONE->EMPTY on out_fire & !in_fire; ONE->ONE on both (head replaced by in_data_i); ONE->TWO on in_fire & !out_fire (DEPTH=2; new payload into skid); TWO->ONE on out_fire (skid moves to head, same edge).
REQ-020 Latency: accepted payload appears on out_data_o with out_valid_o=1 exactly one clock after in_fire when stage was EMPTY or head leaves that cycle.
REQ-021 Ordering strictly FIFO; no payload duplicated or dropped except by flush/rst.
REQ-022 stall_i=1: state, head and skid registers hold; out_valid_o keeps its value; in_ready_o=0.
REQ-023 flush_i=1: next state EMPTY, out_valid_o=0, skid invalidated, out_data_o=0 if CLR_ON_FLUSH=1; concurrent in_valid_i payload discarded.
REQ-024 Priority: rst > flush_i > stall_i > normal handshake.
REQ-025 out_data_o when out_valid_o=0 is don't-care except after reset/flush (REQ-023, REQ-027).
REQ-026 Outputs out_valid_o, out_data_o, occupancy_o driven directly from registers.

Reset
REQ-027 rst=1 at rising edge: state EMPTY, out_valid_o=0, out_data_o=0, skid cleared, occupancy_o=0; in_ready_o=0 while rst asserted.
REQ-028 Reset mid-transfer discards held entries; first accept permitted on first edge after rst deasserts.

Verification
REQ-029 DEPTH=2, stream 0x11,0x22,0x33 with out_ready_i=1 -> out_data_o 0x11,0x22,0x33 on consecutive cycles, occupancy_o=1, in_ready_o=1 throughout.
REQ-030 DEPTH=2, out_ready_i=0, push 0xA then 0xB -> occupancy_o 1 then 2, in_ready_o=0; raise out_ready_i -> 0xA then 0xB delivered, occupancy returns 0.
REQ-031 Occupancy 2, stall_i=1 for 3 cycles with out_ready_i=1, in_valid_i=1 -> no change in outputs or occupancy; after release 0xA delivered next edge.
REQ-032 Occupancy 2, flush_i=1 with in_valid_i=1 data 0xC -> next cycle out_valid_o=0, out_data_o=0, occupancy_o=0; 0xC never emitted.
REQ-033 DEPTH=1, head 0x5 held, out_ready_i=1, in_valid_i=1 data 0x6 -> in_ready_o=1 same cycle, out_data_o=0x6 next edge.
REQ-034 rst asserted with occupancy 2 -> next cycle all outputs 0, then push 0x7 -> out_data_o=0x7 one cycle later.
